// File: rtl/pipe_pkg.sv
//==============================================================================
// Module : pipe_pkg
// Brief  : Shared pipeline types: sequencer state encoding and RV32 opcodes.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MUL_WAIT = 2'd2
    } seq_state_t;

    localparam logic [6:0] c_opc_rtype  = 7'b0110011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_ialu   = 7'b0010011;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/hazard_sequencer_if.sv
//==============================================================================
// Module : hazard_sequencer_if
// Brief  : Pipeline observation inputs and control outputs of the sequencer.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface hazard_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             start_i;
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_use_rs2_i;
    logic             ex_memread_i;
    logic [4:0]       ex_rd_i;
    logic             ex_mul_i;
    logic             branch_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             exmem_hold_o;
    logic             busy_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output start_i, id_rs1_i, id_rs2_i, id_use_rs2_i,
               ex_memread_i, ex_rd_i, ex_mul_i, branch_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
               exmem_hold_o, busy_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  start_i, id_rs1_i, id_rs2_i, id_use_rs2_i,
               ex_memread_i, ex_rd_i, ex_mul_i, branch_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
               exmem_hold_o, busy_o, stall_cnt_o, flush_cnt_o
    );

endinterface : hazard_sequencer_if

`default_nettype wire

// File: rtl/hazard_sequencer_sat_counter.sv
//==============================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones instead of wrapping.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             i_inc,
    input  wire logic             i_clear,
    output logic      [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule : sat_counter

`default_nettype wire

// File: rtl/hazard_sequencer.sv
//==============================================================================
// Module : hazard_sequencer
// Brief  : Stall/flush/hold sequencer for the five-stage pipeline.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module hazard_sequencer
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32
) (
    input wire logic         clk_i,
    input wire logic         rst_i,
    hazard_sequencer_if.slave bus
);

    localparam int                    c_mcnt_w    = $clog2(MUL_LAT);
    localparam logic [c_mcnt_w-1:0]   c_mcnt_load = c_mcnt_w'(MUL_LAT - 2);
    localparam logic [c_mcnt_w-1:0]   c_mcnt_one  = c_mcnt_w'(1);

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [c_mcnt_w-1:0] r_mcnt;
    logic [c_mcnt_w-1:0] w_mcnt_nxt;

    logic w_load_use;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_idex_bubble;
    logic w_exmem_hold;
    logic w_busy;
    logic w_stall_inc;

    // x0 is hardwired zero, so a load into it can never create a RAW hazard
    assign w_load_use = bus.ex_memread_i && (bus.ex_rd_i != 5'd0) &&
                        ((bus.ex_rd_i == bus.id_rs1_i) ||
                         (bus.id_use_rs2_i && (bus.ex_rd_i == bus.id_rs2_i)));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_mcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mcnt  <= w_mcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_mcnt_nxt    = r_mcnt;
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_exmem_hold  = 1'b0;
        w_busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.ex_mul_i) begin
                    w_exmem_hold = 1'b1;
                    w_mcnt_nxt   = c_mcnt_load;
                    // A two-cycle multiply is covered entirely by this cycle
                    if (MUL_LAT > 2) begin
                        w_state_nxt = ST_MUL_WAIT;
                    end
                end else if (w_load_use) begin
                    w_idex_bubble = 1'b1;
                end else if (bus.branch_i) begin
                    w_ifid_flush = 1'b1;
                    w_pc_write   = 1'b1;
                    w_ifid_write = 1'b1;
                end else begin
                    w_pc_write   = 1'b1;
                    w_ifid_write = 1'b1;
                end
            end
            ST_MUL_WAIT: begin
                w_busy       = 1'b1;
                w_exmem_hold = 1'b1;
                if (r_mcnt <= c_mcnt_one) begin
                    w_mcnt_nxt  = '0;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_mcnt_nxt  = r_mcnt - c_mcnt_one;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_mcnt_nxt  = '0;
            end
        endcase
    end

    assign w_stall_inc = (r_state != ST_IDLE) && !w_pc_write;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_inc   (w_stall_inc),
        .i_clear (1'b0),
        .o_count (bus.stall_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_inc   (w_ifid_flush),
        .i_clear (1'b0),
        .o_count (bus.flush_cnt_o)
    );

    assign bus.pc_write_o    = w_pc_write;
    assign bus.ifid_write_o  = w_ifid_write;
    assign bus.ifid_flush_o  = w_ifid_flush;
    assign bus.idex_bubble_o = w_idex_bubble;
    assign bus.exmem_hold_o  = w_exmem_hold;
    assign bus.busy_o        = w_busy;

endmodule : hazard_sequencer

`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
//==============================================================================
// Module : tb_hazard_sequencer
// Brief  : Self-checking bench for hazard_sequencer against a cycle model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_hazard_sequencer;

    localparam int c_mul_lat = 4;
    localparam int c_cnt_w   = 4;
    localparam int c_cnt_max = (1 << c_cnt_w) - 1;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    // Model state: running flag, remaining multiply-hold cycles, counters
    bit   m_run;
    int   m_hold;
    int   m_stall;
    int   m_flush;

    hazard_sequencer_if #(.CNT_W(c_cnt_w)) bus ();

    hazard_sequencer #(.MUL_LAT(c_mul_lat), .CNT_W(c_cnt_w)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, busy}
    function automatic logic [5:0] obs();
        return {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o,
                bus.idex_bubble_o, bus.exmem_hold_o, bus.busy_o};
    endfunction

    function automatic logic [5:0] model_eval();
        bit hz;
        hz = bus.ex_memread_i && (bus.ex_rd_i != 0) &&
             ((bus.ex_rd_i == bus.id_rs1_i) ||
              (bus.id_use_rs2_i && (bus.ex_rd_i == bus.id_rs2_i)));
        if (!m_run)           return 6'b000000;
        if (m_hold > 0)       return 6'b000011;
        if (bus.ex_mul_i)     return 6'b000010;
        if (hz)               return 6'b000100;
        if (bus.branch_i)     return 6'b111000;
        return 6'b110000;
    endfunction

    task automatic model_reset();
        m_run = 0; m_hold = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_tick(input logic [5:0] e);
        bit stall_inc;
        stall_inc = m_run && !e[5];
        @(posedge clk);
        if (!m_run)           m_run = bus.start_i;
        else if (m_hold > 0)  m_hold--;
        else if (bus.ex_mul_i) m_hold = c_mul_lat - 2;
        if (stall_inc && m_stall < c_cnt_max) m_stall++;
        if (e[3] && m_flush < c_cnt_max)      m_flush++;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.start_i = 0; bus.id_rs1_i = 0; bus.id_rs2_i = 0; bus.id_use_rs2_i = 0;
        bus.ex_memread_i = 0; bus.ex_rd_i = 0; bus.ex_mul_i = 0; bus.branch_i = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_run();
        logic [5:0] e;
        bus.start_i = 1;
        #1; e = model_eval();
        model_tick(e);
        bus.start_i = 0;
    endtask

    task automatic drive(input bit mr, input int rd, input int rs1, input int rs2,
                         input bit u2, input bit mul, input bit br);
        bus.ex_memread_i = mr; bus.ex_rd_i = 5'(rd); bus.id_rs1_i = 5'(rs1);
        bus.id_rs2_i = 5'(rs2); bus.id_use_rs2_i = u2; bus.ex_mul_i = mul; bus.branch_i = br;
    endtask

    task automatic test_reset();
        logic [5:0] e;
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk); #1;
        n_checks++;
        if (obs() !== 6'b0 || bus.stall_cnt_o !== '0 || bus.flush_cnt_o !== '0) begin
            n_fail++;
            $display("FAIL reset_state got=%b/%0d/%0d exp=0", obs(), bus.stall_cnt_o, bus.flush_cnt_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1; e = model_eval();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL idle_outputs cyc=%0d got=%b exp=%b", i, obs(), e);
            end
            model_tick(e);
        end
        n_checks++;
        if (bus.stall_cnt_o !== '0 || bus.flush_cnt_o !== '0) begin
            n_fail++;
            $display("FAIL idle_counters got=%0d/%0d exp=0/0", bus.stall_cnt_o, bus.flush_cnt_o);
        end
        start_run();
        #1;
        n_checks++;
        if (bus.pc_write_o !== 1'b1 || bus.ifid_write_o !== 1'b1) begin
            n_fail++;
            $display("FAIL start_pc_write got=%b%b exp=11", bus.pc_write_o, bus.ifid_write_o);
        end
    endtask

    task automatic test_load_use();
        logic [5:0] e;
        apply_reset();
        start_run();
        drive(1, 5, 5, 0, 0, 0, 0);
        #1; e = model_eval();
        n_checks++;
        if (obs() !== e || e !== 6'b000100) begin
            n_fail++;
            $display("FAIL load_use_rs1 got=%b exp=%b", obs(), e);
        end
        model_tick(e);
        drive(0, 0, 5, 0, 0, 0, 0);
        #1; e = model_eval();
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL load_use_resume got=%b exp=%b", obs(), e);
        end
        model_tick(e);
        n_checks++;
        if (bus.stall_cnt_o !== c_cnt_w'(1)) begin
            n_fail++;
            $display("FAIL load_use_stall_cnt got=%0d exp=1", bus.stall_cnt_o);
        end
        drive(1, 0, 0, 0, 1, 0, 0);
        #1; e = model_eval();
        n_checks++;
        if (obs() !== e || bus.pc_write_o !== 1'b1) begin
            n_fail++;
            $display("FAIL load_x0_no_stall got=%b exp=%b", obs(), e);
        end
        model_tick(e);
        drive(1, 7, 1, 7, 0, 0, 0);
        #1; e = model_eval();
        n_checks++;
        if (obs() !== e || bus.pc_write_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rs2_unused_no_stall got=%b exp=%b", obs(), e);
        end
        model_tick(e);
        for (int i = 0; i < 40; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1), 0, 0);
            #1; e = model_eval();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL load_use_rand cyc=%0d got=%b exp=%b", i, obs(), e);
            end
            model_tick(e);
        end
        n_checks++;
        if (bus.stall_cnt_o !== c_cnt_w'(m_stall)) begin
            n_fail++;
            $display("FAIL load_use_rand_cnt got=%0d exp=%0d", bus.stall_cnt_o, m_stall);
        end
    endtask

    task automatic test_branch();
        logic [5:0] e;
        apply_reset();
        start_run();
        drive(0, 0, 0, 0, 0, 0, 1);
        #1; e = model_eval();
        n_checks++;
        if (obs() !== e || bus.ifid_flush_o !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_flush got=%b exp=%b", obs(), e);
        end
        model_tick(e);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (bus.ifid_flush_o !== 1'b0 || bus.flush_cnt_o !== c_cnt_w'(1)) begin
            n_fail++;
            $display("FAIL branch_one_cycle got=%b/%0d exp=0/1", bus.ifid_flush_o, bus.flush_cnt_o);
        end
        drive(1, 9, 9, 0, 0, 0, 1);
        #1; e = model_eval();
        n_checks++;
        if (obs() !== e || bus.ifid_flush_o !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_vs_load_use got=%b exp=%b", obs(), e);
        end
        model_tick(e);
        n_checks++;
        if (bus.flush_cnt_o !== c_cnt_w'(1) || bus.stall_cnt_o !== c_cnt_w'(1)) begin
            n_fail++;
            $display("FAIL branch_counters got=%0d/%0d exp=1/1", bus.flush_cnt_o, bus.stall_cnt_o);
        end
    endtask

    task automatic test_mul();
        logic [5:0] e;
        int holds, busys;
        apply_reset();
        start_run();
        holds = 0; busys = 0;
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            #1; e = model_eval();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL mul_seq cyc=%0d got=%b exp=%b", i, obs(), e);
            end
            holds += int'(bus.exmem_hold_o);
            busys += int'(bus.busy_o);
            model_tick(e);
            drive(0, 0, 0, 0, 0, 0, 1);
        end
        n_checks++;
        if (holds != c_mul_lat - 1 || busys != c_mul_lat - 2 || bus.stall_cnt_o !== c_cnt_w'(c_mul_lat - 1)) begin
            n_fail++;
            $display("FAIL mul_totals got=%0d/%0d/%0d exp=%0d/%0d/%0d", holds, busys,
                     bus.stall_cnt_o, c_mul_lat - 1, c_mul_lat - 2, c_mul_lat - 1);
        end
        n_checks++;
        if (bus.flush_cnt_o !== c_cnt_w'(m_flush)) begin
            n_fail++;
            $display("FAIL mul_branch_ignored got=%0d exp=%0d", bus.flush_cnt_o, m_flush);
        end
    endtask

    task automatic test_mul_reset();
        logic [5:0] e;
        apply_reset();
        start_run();
        drive(1, 3, 3, 0, 0, 0, 0);
        #1; e = model_eval();
        model_tick(e);
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            #1; e = model_eval();
            model_tick(e);
            drive(0, 0, 0, 0, 0, 0, 0);
        end
        #1;
        n_checks++;
        if (bus.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_wait_before_reset got=%b exp=1", bus.busy_o);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs() !== 6'b0 || bus.stall_cnt_o !== '0) begin
            n_fail++;
            $display("FAIL mul_abort got=%b/%0d exp=0/0", obs(), bus.stall_cnt_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; e = model_eval();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL post_reset_idle cyc=%0d got=%b exp=%b", i, obs(), e);
            end
            model_tick(e);
        end
    endtask

    task automatic test_saturation();
        logic [5:0] e;
        apply_reset();
        start_run();
        for (int i = 0; i < 2 * (c_cnt_max + 4); i++) begin
            if (i % 2 == 0) drive(1, 4, 4, 0, 0, 0, 0);
            else            drive(0, 0, 0, 0, 0, 0, 1);
            #1; e = model_eval();
            model_tick(e);
        end
        n_checks++;
        if (bus.stall_cnt_o !== c_cnt_w'(c_cnt_max) || bus.flush_cnt_o !== c_cnt_w'(c_cnt_max)) begin
            n_fail++;
            $display("FAIL saturate got=%0d/%0d exp=%0d/%0d", bus.stall_cnt_o, bus.flush_cnt_o,
                     c_cnt_max, c_cnt_max);
        end
    endtask

    task automatic test_random();
        logic [5:0] e;
        apply_reset();
        start_run();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1),
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 1));
            #1; e = model_eval();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, obs(), e);
            end
            model_tick(e);
            n_checks++;
            if (bus.stall_cnt_o !== c_cnt_w'(m_stall) || bus.flush_cnt_o !== c_cnt_w'(m_flush)) begin
                n_fail++;
                $display("FAIL random_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", i,
                         bus.stall_cnt_o, bus.flush_cnt_o, m_stall, m_flush);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch();
        test_mul();
        test_mul_reset();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hazard_sequencer

`default_nettype wire

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline sequencer for the five-stage RISC-V core. Sits beside the main decoder: watches ID-stage operands, EX-stage load and multiply status, and the decoder's taken-branch signal. Drives pipeline-register write enables, ID/EX bubble insertion and IF/ID flush. Holds the pipeline for multi-cycle `mul`, keeps two saturating performance counters, and gates execution until `start_i`.

## Interface
- `MUL_LAT`, 4, cycles a `mul` occupies EX (legal range 2..16)
- `CNT_W`, 32, performance counter width

- `clk_i`  in  1  clock, all state on rising edge
- `rst_i`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  run enable; sampled high once to leave IDLE
- `id_rs1_i`  in  5  ID-stage rs1 index
- `id_rs2_i`  in  5  ID-stage rs2 index
- `id_use_rs2_i`  in  1  ID instruction reads rs2 (R-type, store, branch)
- `ex_memread_i`  in  1  EX instruction is a load
- `ex_rd_i`  in  5  EX destination index
- `ex_mul_i`  in  1  EX instruction is `mul` (first EX cycle)
- `branch_i`  in  1  taken branch resolved in ID
- `pc_write_o`  out  1  PC update enable
- `ifid_write_o`  out  1  IF/ID register enable
- `ifid_flush_o`  out  1  zero IF/ID on next edge
- `idex_bubble_o`  out  1  load zero control into ID/EX
- `exmem_hold_o`  out  1  freeze ID/EX and EX stage, bubble into EX/MEM
- `busy_o`  out  1  multiply wait in progress
- `stall_cnt_o`  out  CNT_W  stalled-cycle count
- `flush_cnt_o`  out  CNT_W  flush count

## Operation
- States: IDLE, RUN, MUL_WAIT.
- IDLE: all enables 0, all flush/bubble/hold 0. `start_i`=1 -> RUN next edge. Counters frozen.
- RUN, evaluated in priority order:
  - `ex_mul_i`=1 -> MUL_WAIT; load `mcnt` = MUL_LAT-2. In this cycle: `pc_write_o`=0, `ifid_write_o`=0, `exmem_hold_o`=1, no flush.
  - Load-use: `ex_memread_i`=1, `ex_rd_i`≠0, and (`ex_rd_i`==`id_rs1_i` or (`id_use_rs2_i` and `ex_rd_i`==`id_rs2_i`)) -> `pc_write_o`=0, `ifid_write_o`=0, `idex_bubble_o`=1. `branch_i` ignored this cycle.
  - `branch_i`=1 -> `ifid_flush_o`=1, `pc_write_o`=1, `ifid_write_o`=1.
  - Otherwise `pc_write_o`=`ifid_write_o`=1, the others 0.
- MUL_WAIT: `busy_o`=1, `pc_write_o`=`ifid_write_o`=0, `exmem_hold_o`=1, and `branch_i` and hazards are ignored. `mcnt` decrements each cycle. When `mcnt`==0, the state returns to RUN on the next edge.
- The total hold on `exmem_hold_o` is exactly MUL_LAT-1 cycles per `mul`.
- `stall_cnt_o` increments in any RUN/MUL_WAIT cycle with `pc_write_o`=0. `flush_cnt_o` increments on each cycle with `ifid_flush_o`=1. Both saturate at all-ones and never wrap.
- `start_i` deassertion after leaving IDLE has no effect. Only reset returns to IDLE.

## Timing
- Reset (async, `rst_i`=0) sets state IDLE, `mcnt`=0, counters 0. All outputs are 0 while in reset and in IDLE.
- Control outputs are combinational from state and inputs, with zero-cycle latency to the datapath registers. State, `mcnt` and counters are registered.
- A load-use stall lasts exactly 1 cycle: the next edge moves the load to MEM, so the condition clears.
- Back-to-back `mul`: the second `mul` reaches EX only after RUN resumes, then re-enters MUL_WAIT. There is no idle RUN cycle requirement.
- A reset asserted mid MUL_WAIT aborts immediately. The counters clear and the pipeline state belongs to the datapath reset.
- `ex_rd_i`==0 never causes a stall.

## Structure
- Shared package `pipe_pkg`: state enum (IDLE/RUN/MUL_WAIT) and opcode constants already used by the decoder (R-type 0110011, load 0000011, store 0100011, branch 1100011, I-ALU 0010011).
- One natural sub-module: `sat_counter` (parameter width; inputs inc, clear), instantiated twice for the performance counters.
- `mcnt` width is $clog2(MUL_LAT).

## Test plan
- Reset then `start_i` low for 5 cycles -> all enables 0, counters 0. Pulse `start_i` -> `pc_write_o`=1 on the following cycle.
- Load x5 in EX, ID reads rs1=5 -> one cycle with `pc_write_o`=0 and `idex_bubble_o`=1, then resume; `stall_cnt_o`=1.
- Load x0 in EX, ID reads rs1=0 -> no stall. Load x7, ID rs2=7 with `id_use_rs2_i`=0 -> no stall.
- `branch_i`=1 without hazard -> `ifid_flush_o`=1 for one cycle, `flush_cnt_o`=1. Same with a simultaneous load-use on rs1 -> stall wins, flush 0.
- MUL_LAT=4, `ex_mul_i` pulse -> `exmem_hold_o` high exactly 3 cycles, `busy_o` high 2, `stall_cnt_o`=3. `branch_i` held high during the hold is ignored until RUN.
- `rst_i` low in the second MUL_WAIT cycle -> outputs 0 immediately. After release, the block is in IDLE until `start_i`. Force the counters near all-ones -> they saturate and do not wrap.
